// File: rtl/seq_det_pkg.sv
// Shared defaults and parameter sanity check for the serial pattern detector.
package seq_det_pkg;

  localparam int          DEF_PAT_W   = 5;
  localparam int          DEF_CNT_W   = 8;
  localparam logic [31:0] DEF_PATTERN = 32'b11001;

  // True when the pattern length is 2..32 and the pattern has no bits above it.
  function automatic bit params_ok(input int pat_w, input logic [31:0] pattern);
    bit ok;
    ok = (pat_w >= 2) && (pat_w <= 32);
    if (ok && (pat_w < 32)) begin
      ok = ((pattern >> pat_w) == 32'd0);
    end
    return ok;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear together with inc
// yields 1 so the event arriving in the clear cycle is kept.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] count_o
);

  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear wins over hold, inc stops at all-ones.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = inc_i ? W'(1) : '0;
    end else if (inc_i && (count_q != MAX)) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/seq_detect_param.sv
// Parametrised serial bit-pattern detector with overlap control, a valid
// qualifier, Mealy and registered match outputs and a saturating match count.
module seq_detect_param
  import seq_det_pkg::*;
#(
  parameter int          PAT_W   = DEF_PAT_W,
  parameter logic [31:0] PATTERN = DEF_PATTERN,
  parameter int          CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             overlap,
  input  logic             count_clr,
  output logic             y,
  output logic             y_q,
  output logic [CNT_W-1:0] match_count
);

  localparam int                 FW       = $clog2(PAT_W);
  localparam logic [FW-1:0]      FILL_MAX = FW'(PAT_W - 1);
  localparam logic [PAT_W-1:0]   PAT      = PATTERN[PAT_W-1:0];

  if (!params_ok(PAT_W, PATTERN)) begin : g_bad_params
    $error("seq_detect_param: PAT_W must be 2..32 and PATTERN must fit in PAT_W bits");
  end

  // Only the newest PAT_W-1 history bits ever reach the compare window,
  // so the oldest bit is not stored.
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic             y_reg_q;
  logic [PAT_W-1:0] window;

  // Compare window, Mealy match and next history/fill.
  always_comb begin
    window = {hist_q, din};
    y      = din_valid && (fill_q == FILL_MAX) && (window == PAT);
    hist_d = hist_q;
    fill_d = fill_q;
    if (din_valid) begin
      hist_d = window[PAT_W-2:0];
      if (y) begin
        // Non-overlap restarts the fill so the next match needs PAT_W fresh bits.
        fill_d = overlap ? FILL_MAX : '0;
      end else if (fill_q != FILL_MAX) begin
        fill_d = fill_q + FW'(1);
      end
    end
  end

  // History, fill level and registered match; y is 0 on invalid cycles so
  // y_q clears there on its own.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hist_q  <= '0;
      fill_q  <= '0;
      y_reg_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      y_reg_q <= y;
    end
  end

  assign y_q = y_reg_q;

  sat_counter #(
    .W(CNT_W)
  ) u_match_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc_i   (y),
    .clr_i   (count_clr),
    .count_o (match_count)
  );

endmodule
